tt_um_jleugeri_ttt_event_queue: RTL and testbench
=================================================

// Module: tt_um_jleugeri_ttt_event_queue
// PURPOSE
//  Downstream of the token-processor core. Captures each start/stop event the core emits
//  (processor_id_out, token_startstop, output_valid) and stamps it with a step counter.
//  Events are buffered in a FIFO and drained over a valid/ready handshake toward the
//  output/readback logic. Bursts of events within one slow step never stall the core.
//  Overflow is reported sticky, with a saturating drop count.
// PARAMETERS
//  NUM_PROCESSORS  10  number of processors; PID_BITS = $clog2(NUM_PROCESSORS)
//  DEPTH           8   FIFO entries; power of two, >= 2
//  TIMESTAMP_BITS  8   width of step counter / stored timestamp
//  DROP_BITS       4   width of saturating dropped-event counter
// PORTS
//  clock_fast         in   1                      single clock, all flops on rising edge
//  reset              in   1                      asynchronous, active-high
//  tick               in   1                      1-cycle pulse: slow step advanced
//  event_valid        in   1                      core output_valid
//  processor_id_in    in   PID_BITS               core processor_id_out
//  token_startstop_in in   2                      01 start, 10 stop, 11 both, 00 none
//  out_valid          out  1                      head entry available
//  out_ready          in   1                      consumer accepts head this cycle
//  processor_id_out   out  PID_BITS               head processor id
//  token_startstop    out  2                      head start/stop code
//  timestamp_out      out  TIMESTAMP_BITS         head timestamp
//  fill_level         out  $clog2(DEPTH+1)        entries currently stored
//  overflow           out  1                      sticky: >=1 event dropped
//  dropped_count      out  DROP_BITS              dropped events, saturates at all-ones
//  clear_overflow     in   1                      clears overflow and dropped_count
// BEHAVIOUR
//  Reset (async, any cycle): pointers, fill_level, step counter, overflow, dropped_count
//   all 0; out_valid=0; data outputs 0. In-flight and stored events are discarded.
//  Step counter: +1 on each cycle with tick=1; wraps 2^TIMESTAMP_BITS-1 -> 0.
//  Push request: event_valid=1 and token_startstop_in!=00. Code 00 is ignored, never counted.
//   Stored timestamp = counter value before that cycle's tick increment.
//  Pop: out_valid & out_ready. out_ready while out_valid=0 has no effect.
//  FIFO is show-ahead. out_valid = (fill_level!=0). Data outputs show the head entry and are
//   0 when empty. Write-to-visible latency is 1 cycle. No same-cycle bypass when empty.
//  Holding: head data and out_valid remain stable until popped.
//  Full, push, no pop: event dropped; overflow<=1; dropped_count+1 (saturating).
//  Full, push and pop in same cycle: both succeed; fill_level unchanged; no drop.
//  Empty, push and out_ready=1: push succeeds; nothing popped this cycle.
//  fill_level: +1 push only, -1 pop only, unchanged if both/neither; never exceeds DEPTH.
//  Pointers: log2(DEPTH) bits, wrap naturally. Full/empty derive from fill_level.
//  clear_overflow=1: overflow<=0, dropped_count<=0. If a drop occurs the same cycle,
//   the drop is applied after the clear: overflow=1, dropped_count=1.
//  processor_id_in is stored unchecked; range checking belongs to the core.
// TESTING
//  1 reset mid-stream, 3 entries queued -> next cycle out_valid=0, fill_level=0,
//    overflow=0; outputs stay 0.
//  2 counter=5; push id=3 code=01; out_ready=0 -> next cycle out_valid=1, id=3,
//    code=01, ts=5, fill_level=1. Outputs held until ready=1, then empty.
//  3 push id=2 code=10 with tick in same cycle, counter=7 -> entry ts=7, counter=8.
//    Counter at 255 + tick -> 0.
//  4 out_ready=0; DEPTH+3 pushes -> fill_level=DEPTH, overflow=1, dropped_count=3.
//    Drain returns the first DEPTH events in order.
//  5 full FIFO; push and pop same cycle -> fill_level stays DEPTH; no new drop.
//    Popped=oldest; new entry last.
//  6 dropped_count at 15 + drop -> stays 15. clear_overflow with simultaneous drop ->
//    overflow=1, count=1. Push with code=00 -> fill_level unchanged.

Source files
------------

// File: rtl/tt_um_jleugeri_ttt_event_queue.sv
// Event queue behind the token-processor core.
// Timestamps start/stop events and buffers them for the readback side.
module tt_um_jleugeri_ttt_event_queue #(
    parameter int NUM_PROCESSORS = 10,
    parameter int DEPTH          = 8,
    parameter int TIMESTAMP_BITS = 8,
    parameter int DROP_BITS      = 4,
    localparam int PID_BITS  = $clog2(NUM_PROCESSORS),
    localparam int FILL_BITS = $clog2(DEPTH + 1),
    localparam int PTR_BITS  = $clog2(DEPTH)
) (
    input  logic                      clock_fast,
    input  logic                      reset,
    input  logic                      tick,
    input  logic                      event_valid,
    input  logic [PID_BITS-1:0]       processor_id_in,
    input  logic [1:0]                token_startstop_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PID_BITS-1:0]       processor_id_out,
    output logic [1:0]                token_startstop,
    output logic [TIMESTAMP_BITS-1:0] timestamp_out,
    output logic [FILL_BITS-1:0]      fill_level,
    output logic                      overflow,
    output logic [DROP_BITS-1:0]      dropped_count,
    input  logic                      clear_overflow
);

    logic [PID_BITS-1:0]       pid_mem  [DEPTH];
    logic [1:0]                code_mem [DEPTH];
    logic [TIMESTAMP_BITS-1:0] ts_mem   [DEPTH];

    logic [PTR_BITS-1:0]       wr_ptr;
    logic [PTR_BITS-1:0]       rd_ptr;
    logic [TIMESTAMP_BITS-1:0] step_cnt;

    logic push_req;
    logic full;
    logic pop;
    logic push_ok;
    logic drop;
    logic drop_sat;

    assign push_req = event_valid && (token_startstop_in != 2'b00);
    assign full     = (fill_level == FILL_BITS'(DEPTH));
    assign out_valid = (fill_level != '0);
    assign pop      = out_valid && out_ready;
    // a pop in the same cycle frees the slot the push needs
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;
    assign drop_sat = (dropped_count == {DROP_BITS{1'b1}});

    // show-ahead head; zeroed while empty so stale slots never leak out
    assign processor_id_out = out_valid ? pid_mem[rd_ptr]  : '0;
    assign token_startstop  = out_valid ? code_mem[rd_ptr] : '0;
    assign timestamp_out    = out_valid ? ts_mem[rd_ptr]   : '0;

    // storage write; timestamp is the count before this cycle's tick
    always_ff @(posedge clock_fast) begin
        if (push_ok) begin
            pid_mem[wr_ptr]  <= processor_id_in;
            code_mem[wr_ptr] <= token_startstop_in;
            ts_mem[wr_ptr]   <= step_cnt;
        end
    end

    // slow-step counter, wraps naturally
    always_ff @(posedge clock_fast or posedge reset) begin
        if (reset) begin
            step_cnt <= '0;
        end else if (tick) begin
            step_cnt <= step_cnt + TIMESTAMP_BITS'(1);
        end
    end

    // pointers and occupancy
    always_ff @(posedge clock_fast or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_BITS'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_BITS'(1);
            end
            if (push_ok && !pop) begin
                fill_level <= fill_level + FILL_BITS'(1);
            end else if (pop && !push_ok) begin
                fill_level <= fill_level - FILL_BITS'(1);
            end
        end
    end

    // sticky overflow and saturating drop count; a same-cycle drop wins over clear
    always_ff @(posedge clock_fast or posedge reset) begin
        if (reset) begin
            overflow      <= 1'b0;
            dropped_count <= '0;
        end else if (clear_overflow) begin
            overflow      <= drop;
            dropped_count <= drop ? DROP_BITS'(1) : '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (!drop_sat) begin
                dropped_count <= dropped_count + DROP_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_event_queue.sv
// Scoreboard bench for the event queue.
// Directed steps; expected entries queued on push, compared on pop.
module tb_tt_um_jleugeri_ttt_event_queue;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       ev_valid;
    logic [3:0] pid_in;
    logic [1:0] code_in;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] pid_out;
    logic [1:0] code_out;
    logic [7:0] ts_out;
    logic [3:0] fill;
    logic       ovf;
    logic [3:0] dcnt;
    logic       clr;

    typedef struct packed {
        logic [3:0] pid;
        logic [1:0] code;
        logic [7:0] ts;
    } ev_t;

    ev_t        q[$];
    logic [7:0] m_cnt;
    logic       m_ov;
    logic [3:0] m_dc;
    int         checks = 0;
    int         errors = 0;

    tt_um_jleugeri_ttt_event_queue dut (
        .clock_fast         (clk),
        .reset              (rst),
        .tick               (tick),
        .event_valid        (ev_valid),
        .processor_id_in    (pid_in),
        .token_startstop_in (code_in),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .processor_id_out   (pid_out),
        .token_startstop    (code_out),
        .timestamp_out      (ts_out),
        .fill_level         (fill),
        .overflow           (ovf),
        .dropped_count      (dcnt),
        .clear_overflow     (clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic check_state();
        check("fill", 32'(fill), 32'(q.size()));
        check("valid", 32'(out_valid), 32'(q.size() != 0));
        check("ovf", 32'(ovf), 32'(m_ov));
        check("dcnt", 32'(dcnt), 32'(m_dc));
        if (q.size() != 0) begin
            check("head_pid", 32'(pid_out), 32'(q[0].pid));
            check("head_code", 32'(code_out), 32'(q[0].code));
            check("head_ts", 32'(ts_out), 32'(q[0].ts));
        end else begin
            check("empty_data", {pid_out, code_out, ts_out}, 32'd0);
        end
    endtask

    // drive one cycle, update the model, then check after the edge
    task automatic cyc(input logic ev, input logic [3:0] pid,
                       input logic [1:0] code, input logic tk,
                       input logic rdy, input logic cl);
        logic preq;
        logic pop;
        logic drp;
        ev_valid  = ev;
        pid_in    = pid;
        code_in   = code;
        tick      = tk;
        out_ready = rdy;
        clr       = cl;
        preq = ev && (code != 2'b00);
        pop  = (q.size() != 0) && rdy;
        drp  = 1'b0;
        if (pop) begin
            check("pop_pid", 32'(pid_out), 32'(q[0].pid));
            check("pop_ts", 32'(ts_out), 32'(q[0].ts));
            void'(q.pop_front());
        end
        if (preq) begin
            if (q.size() < DEPTH) q.push_back('{pid, code, m_cnt});
            else drp = 1'b1;
        end
        if (cl) begin
            m_ov = 1'b0;
            m_dc = 4'd0;
        end
        if (drp) begin
            m_ov = 1'b1;
            if (m_dc != 4'hf) m_dc = m_dc + 4'd1;
        end
        if (tk) m_cnt = m_cnt + 8'd1;
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 4'd0, 2'b00, 1'b0, rdy, 1'b0);
    endtask

    task automatic model_reset();
        q.delete();
        m_cnt = 8'd0;
        m_ov  = 1'b0;
        m_dc  = 4'd0;
    endtask

    initial begin
        rst = 1'b1;
        tick = 1'b0;
        ev_valid = 1'b0;
        pid_in = '0;
        code_in = '0;
        out_ready = 1'b0;
        clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state();
        rst = 1'b0;

        // counter to 5, push and hold
        repeat (5) cyc(1'b0, 4'd0, 2'b00, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 4'd3, 2'b01, 1'b0, 1'b0, 1'b0);
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_pid", 32'(pid_out), 32'd3);
        check("t2_code", 32'(code_out), 32'd1);
        check("t2_ts", 32'(ts_out), 32'd5);
        check("t2_fill", 32'(fill), 32'd1);
        idle(1'b0);
        idle(1'b0);
        check("t2_hold_pid", 32'(pid_out), 32'd3);
        idle(1'b1);
        check("t2_empty", 32'(out_valid), 32'd0);

        // push with tick in same cycle
        repeat (2) cyc(1'b0, 4'd0, 2'b00, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 4'd2, 2'b10, 1'b1, 1'b0, 1'b0);
        check("t3_ts7", 32'(ts_out), 32'd7);
        cyc(1'b1, 4'd4, 2'b11, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        check("t3_ts8", 32'(ts_out), 32'd8);
        idle(1'b1);

        // counter wrap 255 -> 0
        repeat (247) cyc(1'b0, 4'd0, 2'b00, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 4'd1, 2'b01, 1'b1, 1'b0, 1'b0);
        check("t3_ts255", 32'(ts_out), 32'd255);
        cyc(1'b1, 4'd1, 2'b10, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        check("t3_wrap0", 32'(ts_out), 32'd0);
        idle(1'b1);

        // empty with push and ready together: nothing popped
        cyc(1'b1, 4'd6, 2'b01, 1'b0, 1'b1, 1'b0);
        check("empty_push_fill", 32'(fill), 32'd1);
        idle(1'b1);

        // asynchronous reset mid-stream
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 4'(i), 2'b01, 1'b1, 1'b0, 1'b0);
        ev_valid = 1'b0;
        tick = 1'b0;
        code_in = 2'b00;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("t1_async_fill", 32'(fill), 32'd0);
        check_state();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1'b0);

        // overflow: DEPTH+3 pushes without draining
        for (int i = 0; i < DEPTH + 3; i++)
            cyc(1'b1, 4'(i), 2'b01, 1'b0, 1'b0, 1'b0);
        check("t4_fill", 32'(fill), 32'(DEPTH));
        check("t4_ovf", 32'(ovf), 32'd1);
        check("t4_dcnt", 32'(dcnt), 32'd3);

        // full with push and pop together
        cyc(1'b1, 4'd9, 2'b11, 1'b0, 1'b1, 1'b0);
        check("t5_fill", 32'(fill), 32'(DEPTH));
        check("t5_dcnt", 32'(dcnt), 32'd3);
        for (int i = 0; i < DEPTH; i++) idle(1'b1);
        check("t5_drained", 32'(fill), 32'd0);

        // drop counter saturation
        for (int i = 0; i < DEPTH + 12; i++)
            cyc(1'b1, 4'(i), 2'b10, 1'b0, 1'b0, 1'b0);
        check("t6_dcnt15", 32'(dcnt), 32'd15);
        cyc(1'b1, 4'd7, 2'b10, 1'b0, 1'b0, 1'b0);
        check("t6_sat", 32'(dcnt), 32'd15);

        // clear with simultaneous drop
        cyc(1'b1, 4'd7, 2'b01, 1'b0, 1'b0, 1'b1);
        check("t6_clr_ovf", 32'(ovf), 32'd1);
        check("t6_clr_cnt", 32'(dcnt), 32'd1);
        cyc(1'b0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b1);
        check("t6_cleared", 32'(dcnt), 32'd0);

        // code 00 is ignored
        idle(1'b1);
        cyc(1'b1, 4'd5, 2'b00, 1'b0, 1'b0, 1'b0);
        check("t6_code00", 32'(fill), 32'(DEPTH - 1));
        check("t6_no_ovf", 32'(ovf), 32'd0);
        for (int i = 0; i < DEPTH; i++) idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
